// File: rtl/flash_arbiter.sv
// Round-robin arbiter letting two requesters share one flash core port.
// Ownership is held for a whole burst, but a waiting peer forces release after MAX_BEATS beats.
module flash_arbiter #(
  parameter int ADDR_BITS = 24,
  parameter int MAX_BEATS = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 m0_cs,
  input  logic [ADDR_BITS-3:0] m0_addr,
  input  logic                 m0_burst,
  output logic [31:0]          m0_dout,
  output logic                 m0_ack,
  input  logic                 m1_cs,
  input  logic [ADDR_BITS-3:0] m1_addr,
  input  logic                 m1_burst,
  output logic [31:0]          m1_dout,
  output logic                 m1_ack,
  output logic                 mem_cs,
  output logic [ADDR_BITS-3:0] mem_addr,
  output logic                 mem_burst,
  input  logic [31:0]          mem_dout,
  input  logic                 mem_busy,
  input  logic                 mem_ack,
  output logic [1:0]           grant,
  output logic [1:0]           state_dbg
);

  // Requester/core handshake: a requester holds cs until its access is done and
  // takes one word per cycle in which its ack is high; the arbiter never stalls an ack.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN0  = 2'd1,
    OWN1  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam logic [7:0] LAST_BEAT = 8'(MAX_BEATS - 1);
  localparam logic [7:0] SAT_BEAT  = 8'(MAX_BEATS);

  state_t     state;
  logic       last1;
  logic [7:0] beats;
  logic       other_cs;
  logic       final_beat;
  logic       force_rel;

  assign state_dbg = state;

  // A peer that raises cs after the counter saturated must still get a turn, hence >=.
  assign other_cs   = (state == OWN0) ? m1_cs : m0_cs;
  assign final_beat = (beats >= LAST_BEAT) && other_cs;
  assign force_rel  = final_beat && mem_ack;

  always_comb begin
    mem_cs    = 1'b0;
    mem_addr  = '0;
    mem_burst = 1'b0;
    m0_ack    = 1'b0;
    m0_dout   = '0;
    m1_ack    = 1'b0;
    m1_dout   = '0;
    case (state)
      OWN0: begin
        mem_cs    = m0_cs;
        mem_addr  = m0_addr;
        mem_burst = m0_burst & ~final_beat;
        m0_ack    = mem_ack;
        m0_dout   = mem_dout;
      end
      OWN1: begin
        mem_cs    = m1_cs;
        mem_addr  = m1_addr;
        mem_burst = m1_burst & ~final_beat;
        m1_ack    = mem_ack;
        m1_dout   = mem_dout;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      grant <= 2'b00;
      last1 <= 1'b1;
      beats <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (m0_cs && (!m1_cs || last1)) begin
            state <= OWN0;
            grant <= 2'b01;
          end else if (m1_cs) begin
            state <= OWN1;
            grant <= 2'b10;
          end
        end
        OWN0: begin
          if (mem_ack && beats != SAT_BEAT) beats <= beats + 8'd1;
          if (!m0_cs || force_rel) begin
            state <= DRAIN;
            grant <= 2'b00;
            last1 <= 1'b0;
          end
        end
        OWN1: begin
          if (mem_ack && beats != SAT_BEAT) beats <= beats + 8'd1;
          if (!m1_cs || force_rel) begin
            state <= DRAIN;
            grant <= 2'b00;
            last1 <= 1'b1;
          end
        end
        DRAIN: begin
          if (!mem_busy) begin
            state <= IDLE;
            beats <= '0;
          end
        end
        default: begin
          state <= IDLE;
          grant <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_flash_arbiter.sv
// Bench for flash_arbiter: directed scenarios, then random requesters against a
// flash-core model whose per-port expected-data queues are keyed by address space.
module tb_flash_arbiter;

  localparam int AW = 22;
  localparam int MB = 4;

  logic          clk;
  logic          rst;
  logic          cs_v[2];
  logic [AW-1:0] addr_v[2];
  logic          burst_v[2];
  logic          m0_cs, m1_cs, m0_burst, m1_burst;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [31:0]   m0_dout, m1_dout;
  logic          m0_ack, m1_ack;
  logic          mem_cs, mem_burst, mem_busy, mem_ack;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_dout;
  logic [1:0]    grant, state_dbg;
  logic          ack_v[2];
  logic [31:0]   dout_v[2];

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];

  assign m0_cs    = cs_v[0];
  assign m1_cs    = cs_v[1];
  assign m0_addr  = addr_v[0];
  assign m1_addr  = addr_v[1];
  assign m0_burst = burst_v[0];
  assign m1_burst = burst_v[1];
  assign ack_v[0]  = m0_ack;
  assign ack_v[1]  = m1_ack;
  assign dout_v[0] = m0_dout;
  assign dout_v[1] = m1_dout;

  flash_arbiter #(.ADDR_BITS(24), .MAX_BEATS(MB)) dut (
    .clk(clk), .rst(rst),
    .m0_cs(m0_cs), .m0_addr(m0_addr), .m0_burst(m0_burst), .m0_dout(m0_dout), .m0_ack(m0_ack),
    .m1_cs(m1_cs), .m1_addr(m1_addr), .m1_burst(m1_burst), .m1_dout(m1_dout), .m1_ack(m1_ack),
    .mem_cs(mem_cs), .mem_addr(mem_addr), .mem_burst(mem_burst), .mem_dout(mem_dout),
    .mem_busy(mem_busy), .mem_ack(mem_ack), .grant(grant), .state_dbg(state_dbg)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  // Random-phase requester state
  int   jobs[2];
  int   left[2];
  int   gap[2];
  logic got[2];
  int   cons[2];
  logic all_done;
  logic [31:0] d;

  initial begin
    rst = 1'b1;
    for (int p = 0; p < 2; p++) begin
      cs_v[p] = 1'b0; addr_v[p] = '0; burst_v[p] = 1'b0;
    end
    mem_dout = '0; mem_busy = 1'b0; mem_ack = 1'b0;
    #1;
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_state", 32'(state_dbg), 32'h0);
    chk1("rst_mem_cs", mem_cs, 1'b0);
    chk1("rst_mem_burst", mem_burst, 1'b0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    chk1("rst_m0_ack", m0_ack, 1'b0);
    chk1("rst_m1_ack", m1_ack, 1'b0);
    chk("rst_m0_dout", m0_dout, 32'h0);
    chk("rst_m1_dout", m1_dout, 32'h0);
    tick(); tick();
    rst = 1'b0;

    // Single access from port 0
    cs_v[0] = 1'b1; addr_v[0] = 22'h000010; burst_v[0] = 1'b0;
    #1;
    chk("t1_latency_grant", 32'(grant), 32'h0);
    chk1("t1_latency_cs", mem_cs, 1'b0);
    tick();
    chk("t1_grant", 32'(grant), 32'h1);
    chk1("t1_mem_cs", mem_cs, 1'b1);
    chk("t1_mem_addr", 32'(mem_addr), 32'h10);
    mem_ack = 1'b1; mem_dout = 32'hDEADBEEF;
    #1;
    chk1("t1_m0_ack", m0_ack, 1'b1);
    chk("t1_m0_dout", m0_dout, 32'hDEADBEEF);
    chk1("t1_m1_ack", m1_ack, 1'b0);
    chk("t1_m1_dout", m1_dout, 32'h0);
    tick();
    mem_ack = 1'b0; cs_v[0] = 1'b0;
    #1;
    chk1("t1_ack_once", m0_ack, 1'b0);
    tick();
    chk("t1_drain", 32'(grant), 32'h0);
    tick();

    // Simultaneous requests after reset: port 0 first
    rst = 1'b1; #1; rst = 1'b0;
    cs_v[0] = 1'b1; addr_v[0] = 22'h000020;
    cs_v[1] = 1'b1; addr_v[1] = 22'h200020;
    tick();
    chk("t2_grant0", 32'(grant), 32'h1);
    chk("t2_addr0", 32'(mem_addr), 32'h20);
    mem_ack = 1'b1; mem_dout = 32'h11111111; cs_v[0] = 1'b0;
    #1;
    chk1("t2_m0_ack_on_drop", m0_ack, 1'b1);
    chk1("t2_m1_ack", m1_ack, 1'b0);
    tick();
    mem_ack = 1'b0;
    #1;
    chk("t2_grant_gap", 32'(grant), 32'h0);
    chk1("t2_drain_cs", mem_cs, 1'b0);
    tick(); tick();
    chk("t2_grant1", 32'(grant), 32'h2);
    chk("t2_addr1", 32'(mem_addr), 32'h200020);
    mem_ack = 1'b1; mem_dout = 32'h22222222; cs_v[1] = 1'b0;
    #1;
    chk("t2_m1_dout", m1_dout, 32'h22222222);
    tick(); mem_ack = 1'b0; tick(); tick();

    // Forced release after MB beats while port 1 waits (last served is port 1)
    cs_v[0] = 1'b1; addr_v[0] = 22'h000400; burst_v[0] = 1'b1;
    cs_v[1] = 1'b1; addr_v[1] = 22'h200400; burst_v[1] = 1'b1;
    tick();
    chk("t3_grant0", 32'(grant), 32'h1);
    for (int k = 1; k <= MB; k++) begin
      mem_ack = 1'b1; mem_dout = 32'h30000000 + k;
      #1;
      chk1("t3_burst", mem_burst, k != MB);
      chk1("t3_m0_ack", m0_ack, 1'b1);
      chk1("t3_m1_ack", m1_ack, 1'b0);
      chk("t3_addr", 32'(mem_addr), 32'h400 + k - 1);
      tick();
      addr_v[0] = addr_v[0] + 1'b1;
    end
    mem_ack = 1'b1; mem_dout = 32'h3BAD3BAD;
    #1;
    chk("t3_drain_grant", 32'(grant), 32'h0);
    chk1("t3_no_fifth_ack", m0_ack, 1'b0);
    mem_ack = 1'b0;
    tick();
    chk("t3_idle_grant", 32'(grant), 32'h0);
    tick();
    chk("t3_grant1", 32'(grant), 32'h2);
    chk("t3_addr1", 32'(mem_addr), 32'h200400);
    mem_ack = 1'b1; mem_dout = 32'h33333333; cs_v[1] = 1'b0;
    #1;
    chk1("t3_m1_ack", m1_ack, 1'b1);
    chk1("t3_m0_held_no_ack", m0_ack, 1'b0);
    tick(); mem_ack = 1'b0; tick(); tick();
    chk("t3_regrant0", 32'(grant), 32'h1);
    mem_ack = 1'b1; cs_v[0] = 1'b0; burst_v[0] = 1'b0;
    #1;
    chk1("t3_m0_resume", m0_ack, 1'b1);
    tick(); mem_ack = 1'b0; tick(); tick();

    // Port 1 alone: 40-beat burst, no forced release
    cs_v[1] = 1'b1; addr_v[1] = 22'h200800; burst_v[1] = 1'b1;
    tick();
    for (int k = 0; k < 40; k++) begin
      d = $urandom;
      mem_ack = 1'b1; mem_dout = d;
      if (k == 39) cs_v[1] = 1'b0;
      #1;
      chk1("t4_m1_ack", m1_ack, 1'b1);
      chk("t4_m1_dout", m1_dout, d);
      chk("t4_grant", 32'(grant), 32'h2);
      chk1("t4_m0_ack", m0_ack, 1'b0);
      tick();
      addr_v[1] = addr_v[1] + 1'b1;
    end
    mem_ack = 1'b0; burst_v[1] = 1'b0;
    #1;
    chk("t4_drain", 32'(grant), 32'h0);
    tick(); tick();

    // Busy core holds DRAIN; stale ack is dropped (last served is port 1)
    cs_v[0] = 1'b1; addr_v[0] = 22'h000040;
    cs_v[1] = 1'b1; addr_v[1] = 22'h200040;
    tick();
    chk("t5_grant0", 32'(grant), 32'h1);
    mem_ack = 1'b1; mem_dout = 32'h55555555; cs_v[0] = 1'b0; mem_busy = 1'b1;
    #1;
    chk1("t5_m0_ack", m0_ack, 1'b1);
    tick();
    for (int i = 0; i < 5; i++) begin
      mem_ack = (i == 2); mem_dout = 32'hBAD0BAD0;
      #1;
      chk("t5_busy_grant", 32'(grant), 32'h0);
      chk1("t5_busy_cs", mem_cs, 1'b0);
      chk1("t5_stale_m0", m0_ack, 1'b0);
      chk1("t5_stale_m1", m1_ack, 1'b0);
      chk("t5_stale_d0", m0_dout, 32'h0);
      chk("t5_stale_d1", m1_dout, 32'h0);
      tick();
    end
    mem_ack = 1'b0; mem_busy = 1'b0;
    #1;
    chk("t5_busy_fall", 32'(grant), 32'h0);
    tick();
    chk("t5_idle", 32'(grant), 32'h0);
    tick();
    chk("t5_grant1", 32'(grant), 32'h2);
    mem_ack = 1'b1; cs_v[1] = 1'b0;
    #1;
    tick(); mem_ack = 1'b0; tick(); tick();

    // Asynchronous reset in the middle of a port 1 burst
    cs_v[1] = 1'b1; addr_v[1] = 22'h200100; burst_v[1] = 1'b1;
    tick();
    chk("t6_grant1", 32'(grant), 32'h2);
    mem_ack = 1'b1; mem_dout = 32'h66666666;
    #1;
    tick();
    addr_v[1] = addr_v[1] + 1'b1;
    #1;
    chk1("t6_pre_ack", m1_ack, 1'b1);
    rst = 1'b1;
    #1;
    chk("t6_rst_grant", 32'(grant), 32'h0);
    chk1("t6_rst_cs", mem_cs, 1'b0);
    chk1("t6_rst_ack", m1_ack, 1'b0);
    chk("t6_rst_dout", m1_dout, 32'h0);
    mem_ack = 1'b0; cs_v[0] = 1'b1; addr_v[0] = 22'h000200; burst_v[1] = 1'b0;
    #2;
    rst = 1'b0;
    tick();
    chk("t6_tie_port0", 32'(grant), 32'h1);
    mem_ack = 1'b1; cs_v[0] = 1'b0;
    #1;
    tick(); mem_ack = 1'b0; tick(); tick();
    chk("t6_then_port1", 32'(grant), 32'h2);
    mem_ack = 1'b1; cs_v[1] = 1'b0;
    #1;
    tick(); mem_ack = 1'b0; tick(); tick();

    // Random requesters against the flash-core model
    rst = 1'b1; #1; rst = 1'b0;
    for (int p = 0; p < 2; p++) begin
      jobs[p] = 10; left[p] = 0; gap[p] = $urandom_range(0, 3);
      got[p] = 1'b0; cons[p] = 0; cs_v[p] = 1'b0; burst_v[p] = 1'b0;
    end
    all_done = 1'b0;
    for (int cyc = 0; cyc < 8000 && !all_done; cyc++) begin
      tick();
      for (int p = 0; p < 2; p++) begin
        if (got[p]) begin
          got[p] = 1'b0;
          addr_v[p] = addr_v[p] + 1'b1;
          left[p]--;
          if (left[p] == 0) begin
            cs_v[p] = 1'b0; burst_v[p] = 1'b0; gap[p] = $urandom_range(0, 4);
          end
        end else if (!cs_v[p]) begin
          if (gap[p] > 0) gap[p]--;
          else if (jobs[p] > 0) begin
            jobs[p]--;
            left[p] = $urandom_range(1, 10);
            cs_v[p] = 1'b1;
            burst_v[p] = (left[p] > 1);
            addr_v[p] = {p == 1, 21'($urandom_range(0, 4095))};
          end
        end
      end
      #1;
      if (mem_cs) begin
        mem_busy = 1'b0;
        mem_ack = ($urandom_range(0, 1) == 1);
        if (mem_ack) begin
          mem_dout = $urandom;
          if (mem_addr[AW-1]) exp_q1.push_back(mem_dout);
          else exp_q0.push_back(mem_dout);
        end
      end else begin
        mem_ack = 1'b0;
        mem_busy = ($urandom_range(0, 2) == 0);
      end
      #1;
      if (mem_cs) chk1("r_grant_valid", grant == 2'b01 || grant == 2'b10, 1'b1);
      for (int p = 0; p < 2; p++) begin
        if (ack_v[p]) begin
          got[p] = 1'b1;
          chk1("r_ack_while_cs", cs_v[p], 1'b1);
          chk("r_ack_grant", 32'(grant), (p == 1) ? 32'h2 : 32'h1);
          if (p == 0) begin
            chk1("r_q0_nonempty", exp_q0.size() != 0, 1'b1);
            if (exp_q0.size() != 0) chk("r_m0_dout", dout_v[0], exp_q0.pop_front());
          end else begin
            chk1("r_q1_nonempty", exp_q1.size() != 0, 1'b1);
            if (exp_q1.size() != 0) chk("r_m1_dout", dout_v[1], exp_q1.pop_front());
          end
          if (cs_v[1-p]) cons[p]++;
          else cons[p] = 0;
          cons[1-p] = 0;
          chk1("r_fair", cons[p] <= MB, 1'b1);
        end
      end
      all_done = (jobs[0] == 0) && (jobs[1] == 0) && (left[0] == 0) && (left[1] == 0);
    end
    chk1("r_all_done", all_done, 1'b1);
    chk("r_q0_drained", 32'(exp_q0.size()), 32'h0);
    chk("r_q1_drained", 32'(exp_q1.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/flash_arbiter.md
Name: flash_arbiter

Overview:
- Two-requester arbiter sharing one flash core memory-side interface (cs/addr/burst/dout/busy/ack).
- Typical requesters: wishbone memory adapter (CPU path) on port 0, boot/DMA copy engine on port 1.
- Sits between the requesters and the flash core. Round-robin grant, with grant held for the length of a burst and a bounded beat count so neither requester starves the other.

Parameters:
- ADDR_BITS, 24, word-address MSB+1 at the flash core (addresses are [ADDR_BITS-1:2]).
- MAX_BEATS, 16, max acks per grant before forced release when the other requester is waiting; range 1..255.

Ports:
- clk  in  1  main clock
- rst  in  1  asynchronous active-high reset
- m0_cs  in  1  requester 0 access request, held until done
- m0_addr  in  ADDR_BITS-2  requester 0 word address
- m0_burst  in  1  requester 0 sequential-burst hint
- m0_dout  out  32  read data to requester 0
- m0_ack  out  1  read data valid for requester 0, one cycle per beat
- m1_cs, m1_addr, m1_burst, m1_dout, m1_ack  same as port 0, for requester 1
- mem_cs  out  1  to flash core
- mem_addr  out  ADDR_BITS-2  to flash core
- mem_burst  out  1  to flash core
- mem_dout  in  32  from flash core
- mem_busy  in  1  flash core busy
- mem_ack  in  1  flash core beat done
- grant  out  2  one-hot current owner (01 = port 0, 10 = port 1, 00 = none)

Behaviour:
- Reset (async, any time): state IDLE, grant=00, last-served pointer = port 1 (so port 0 wins the first tie), beat counter = 0.
- Reset effect on outputs: mem_cs=0, mem_burst=0, mem_addr=0, m0_ack=0, m1_ack=0, m*_dout=0.
- FSM states: IDLE, OWN0, OWN1, DRAIN.
- IDLE:
  - Only m0_cs set -> OWN0 next cycle; only m1_cs set -> OWN1.
  - Both set -> the port that is not last-served wins.
  - Grant is registered: mem_cs is first asserted in the cycle after the winning cs is seen (1-cycle arbitration latency).
- OWNx, datapath:
  - mem_cs/mem_addr/mem_burst are driven combinationally from port x.
  - mx_ack = mem_ack; mx_dout = mem_dout.
  - Non-owner ack is always 0 and its dout is 0.
- OWNx, beat counting: each mem_ack increments the beat counter, saturating at MAX_BEATS.
- OWNx -> DRAIN, normal release: mx_cs deasserts. Last-served is set to x.
- OWNx -> DRAIN, forced release: mem_ack arrives with counter == MAX_BEATS-1 while the other cs is high. Last-served is set to x.
  - mem_burst is forced to 0 during that final beat cycle.
  - After the forced release, port x's cs stays high and receives no ack until re-granted.
- DRAIN:
  - mem_cs=0, mem_burst=0, grant=00.
  - Stay while mem_busy=1. When mem_busy=0, go to IDLE and clear the counter.
  - Minimum one DRAIN cycle between owners.
- Holding cs during re-arbitration: a requester already holding cs in IDLE with the other idle is re-granted immediately (no fairness penalty without contention).
- mem_ack in IDLE or DRAIN (a stale ack) is dropped and never routed to either port.
- Simultaneous mx_cs drop and mem_ack in OWNx: the ack is delivered, then the FSM goes to DRAIN.
- A requester must not change addr/burst while cs is high except on ack cycles; the arbiter does not check this.

Test Plan:
- Reset, then m0_cs=1, addr=0x000010, burst=0 for one access:
  - grant=01 in the next cycle, mem_cs=1, mem_addr=0x000010.
  - mem_ack with mem_dout=0xDEADBEEF -> m0_ack=1 and m0_dout=0xDEADBEEF for 1 cycle; m1_ack=0.
- Both cs rise in the same cycle after reset:
  - port 0 granted first.
  - Port 0 drops cs after 1 ack -> DRAIN -> port 1 granted. Grant sequence 01, 00, 10.
- MAX_BEATS=4, m0 in a burst with cs held, m1_cs=1:
  - after the 4th ack, mem_burst=0 on that beat, then DRAIN, then grant=10.
  - m0 receives exactly 4 acks before port 1's first ack.
- m1_cs held alone for a 40-beat burst:
  - no forced release; 40 consecutive acks routed to m1; grant stays 10 throughout.
- mem_busy held high for 5 cycles after the owner releases:
  - grant=00 for all 5 cycles; the new owner is granted only after mem_busy falls.
  - A mem_ack injected during DRAIN is not seen on either port.
- Assert rst mid-burst while in OWN1:
  - grant=00, mem_cs=0, m1_ack=0 immediately, without waiting for a clk edge.
  - After release, port 0 wins the next tie.
